// File: rtl/cu_pkg.sv
// cu_pkg
// Shared definitions for the multicycle RV64I control unit.
//   - cu_state_t       : 4-bit control state encoding, S_FETCH (0) .. S_LUI (15)
//   - mux encodings    : mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
//   - is_mem_state     : states that wait on mem_ready before advancing
//   - is_retire_state  : final states of an instruction (return to FETCH retires it)
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_REXEC    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRCMP    = 4'd8,
        S_LINK     = 4'd9,
        S_JAL      = 4'd10,
        S_AUIPC    = 4'd11,
        S_JALR     = 4'd12,
        S_IEXEC    = 4'd13,
        S_BRTAKE   = 4'd14,
        S_LUI      = 4'd15
    } cu_state_t;

    // rd write-back source
    localparam logic [1:0] MTR_ALUOUT   = 2'b00;
    localparam logic [1:0] MTR_MDR      = 2'b01;
    localparam logic [1:0] MTR_PC       = 2'b10;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC      = 2'b00;
    localparam logic [1:0] SRCA_RS1     = 2'b01;
    localparam logic [1:0] SRCA_OLDPC   = 2'b10;
    localparam logic [1:0] SRCA_ZERO    = 2'b11;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;

    // ALU control class
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    // PC load source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    function automatic logic is_mem_state(input cu_state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    function automatic logic is_retire_state(input cu_state_t s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_JAL)   || (s == S_JALR)     || (s == S_BRTAKE);
    endfunction

endpackage

// File: rtl/cu_output_decode.sv
// cu_output_decode
// Pure combinational Moore decode of the control state into datapath controls.
// Ports:
//   state         in   4  current control state
//   mem_ready     in   1  memory completes this cycle (only used in FETCH)
//   pc_write      out  1  unconditional PC load
//   pc_write_cond out  1  PC load qualified by branch flag
//   ir_write      out  1  instruction register load
//   mem_read      out  1  memory read request
//   mem_write     out  1  memory write request
//   i_or_d        out  1  memory address source (0 PC, 1 ALUOut)
//   reg_write     out  1  register file write
//   mem_to_reg    out  2  rd source select
//   alu_src_a     out  2  ALU operand A select
//   alu_src_b     out  2  ALU operand B select
//   alu_op        out  2  ALU control class
//   pc_source     out  2  PC load source select
module cu_output_decode
    import cu_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = MTR_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (cu_state_t'(state))
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC+4 and IR are loaded only on the completing cycle, so a
                // stalled fetch never increments the PC twice.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch/jal target into ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_MDR;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_REXEC: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RFUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_ALUOUT;
            end
            S_BRCMP: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_BRANCH;
            end
            S_LINK: begin
                reg_write  = 1'b1;
                mem_to_reg = MTR_PC;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_ALUOUT;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                pc_write  = 1'b1;
                pc_source = PCSRC_ALU;
            end
            S_IEXEC: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_IFUNCT;
            end
            S_BRTAKE: begin
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_state_sequencer.sv
// cu_state_sequencer
// Registered half of the multicycle RV64I control unit: holds the control
// state, stalls memory states until mem_ready, decodes Moore controls and
// flags illegal opcodes.
// Optional macro CU_PERF_CNT_EN adds cycle_cnt / retired_cnt counters.
// Ports:
//   clk           in   1      system clock
//   rst_n         in   1      synchronous active-low reset
//   ns_in         in   4      next state from the next-state logic
//   mem_ready     in   1      memory completes the current access
//   state_out     out  4      current state register
//   pc_write .. pc_source    datapath controls (see cu_output_decode)
//   cycle_cnt     out  CNT_W  non-reset cycle count   (CU_PERF_CNT_EN only)
//   retired_cnt   out  CNT_W  retired instructions    (CU_PERF_CNT_EN only)
//   illegal_op    out  1      pulse: opcode rejected in DECODE
module cu_state_sequencer
    import cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ns_in,
    input  logic             mem_ready,
    output logic [3:0]       state_out,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
`ifdef CU_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
`endif
    output logic             illegal_op
);

    cu_state_t state_q;
    cu_state_t state_d;

    logic       dec_pc_write;
    logic       dec_pc_write_cond;
    logic       dec_ir_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_i_or_d;
    logic       dec_reg_write;
    logic [1:0] dec_mem_to_reg;
    logic [1:0] dec_alu_src_a;
    logic [1:0] dec_alu_src_b;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_pc_source;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = cu_state_t'(ns_in);
        if (is_mem_state(state_q) && !mem_ready) begin
            state_d = state_q;
        end
    end

    assign state_out = state_q;

    cu_output_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (dec_pc_write),
        .pc_write_cond (dec_pc_write_cond),
        .ir_write      (dec_ir_write),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .i_or_d        (dec_i_or_d),
        .reg_write     (dec_reg_write),
        .mem_to_reg    (dec_mem_to_reg),
        .alu_src_a     (dec_alu_src_a),
        .alu_src_b     (dec_alu_src_b),
        .alu_op        (dec_alu_op),
        .pc_source     (dec_pc_source)
    );

    // Reset is synchronous, so the state register still holds the old state
    // during the reset cycle; masking with rst_n keeps an abandoned
    // instruction from issuing a write before the edge clears the state.
    assign pc_write      = rst_n & dec_pc_write;
    assign pc_write_cond = rst_n & dec_pc_write_cond;
    assign ir_write      = rst_n & dec_ir_write;
    assign mem_read      = rst_n & dec_mem_read;
    assign mem_write     = rst_n & dec_mem_write;
    assign i_or_d        = rst_n & dec_i_or_d;
    assign reg_write     = rst_n & dec_reg_write;
    assign mem_to_reg    = rst_n ? dec_mem_to_reg : 2'b00;
    assign alu_src_a     = rst_n ? dec_alu_src_a  : 2'b00;
    assign alu_src_b     = rst_n ? dec_alu_src_b  : 2'b00;
    assign alu_op        = rst_n ? dec_alu_op     : 2'b00;
    assign pc_source     = rst_n ? dec_pc_source  : 2'b00;

    // The next-state logic signals an unsupported opcode by returning FETCH
    // straight out of DECODE.
    assign illegal_op = rst_n && (state_q == S_DECODE) && (ns_in == 4'd0);

`ifdef CU_PERF_CNT_EN
    // An instruction retires when one of its final states hands back to FETCH;
    // a stalled MEMWRITE does not count until it actually advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (is_retire_state(state_q) && (state_d == S_FETCH)) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cu_state_sequencer.sv
// tb_cu_state_sequencer
// Directed self-checking bench for cu_state_sequencer. Inputs change 1 ns after
// each rising edge; outputs are checked in the same cycle, away from the edge.
// Counter checks are compiled in when CU_PERF_CNT_EN is defined.
module tb_cu_state_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ns_in = 4'd0;
    logic        mem_ready = 1'b0;
    logic [3:0]  state_out;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic        i_or_d, reg_write, illegal_op;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source;
`ifdef CU_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
    //  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}
    logic [16:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

    localparam logic [16:0] C_ZERO     = 17'b0000000_00_00_00_00_00;
    localparam logic [16:0] C_FETCH_WT = 17'b0001000_00_00_01_00_00;
    localparam logic [16:0] C_FETCH_GO = 17'b1011000_00_00_01_00_00;
    localparam logic [16:0] C_DECODE   = 17'b0000000_00_10_10_00_00;
    localparam logic [16:0] C_MEMADDR  = 17'b0000000_00_01_10_00_00;
    localparam logic [16:0] C_MEMREAD  = 17'b0001010_00_00_00_00_00;
    localparam logic [16:0] C_MEMWB    = 17'b0000001_01_00_00_00_00;
    localparam logic [16:0] C_MEMWRITE = 17'b0000110_00_00_00_00_00;
    localparam logic [16:0] C_BRCMP    = 17'b0000000_00_01_00_01_00;
    localparam logic [16:0] C_BRTAKE   = 17'b0100000_00_00_00_00_01;

    logic [3:0]  stateSeq [8];
    logic [16:0] ctrlSeq  [8];

    cu_state_sequencer #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ns_in         (ns_in),
        .mem_ready     (mem_ready),
        .state_out     (state_out),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
`ifdef CU_PERF_CNT_EN
        .cycle_cnt     (cycle_cnt),
        .retired_cnt   (retired_cnt),
`endif
        .illegal_op    (illegal_op)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge with the current inputs, then apply new inputs
    // for the following cycle.
    task automatic applyStimulus(input logic r, input logic [3:0] ns, input logic mr);
        @(posedge clk);
        #1;
        rst_n     = r;
        ns_in     = ns;
        mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check state, control word and illegal_op together.
    task automatic checkCycle(input string tag, input logic [3:0] expState,
                              input logic [16:0] expCtrl, input logic expIllegal);
        checkOutput({tag, "_state"}, 32'(state_out), 32'(expState));
        checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(expCtrl));
        checkOutput({tag, "_illegal"}, 32'(illegal_op), 32'(expIllegal));
    endtask

    initial begin
        stateSeq[0] = 4'd6;  ctrlSeq[0] = 17'b0000000_00_01_00_10_00;
        stateSeq[1] = 4'd7;  ctrlSeq[1] = 17'b0000001_00_00_00_00_00;
        stateSeq[2] = 4'd9;  ctrlSeq[2] = 17'b0000001_10_00_00_00_00;
        stateSeq[3] = 4'd10; ctrlSeq[3] = 17'b1000000_00_00_00_00_01;
        stateSeq[4] = 4'd11; ctrlSeq[4] = 17'b0000000_00_10_10_00_00;
        stateSeq[5] = 4'd12; ctrlSeq[5] = 17'b1000000_00_01_10_00_00;
        stateSeq[6] = 4'd13; ctrlSeq[6] = 17'b0000000_00_01_10_11_00;
        stateSeq[7] = 4'd15; ctrlSeq[7] = 17'b0000000_00_11_10_00_00;

        $display("[TB] reset");
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkCycle("rst1", 4'd0, C_ZERO, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkCycle("rst2", 4'd0, C_ZERO, 1'b0);

        $display("[TB] fetch stall");
        applyStimulus(1'b1, 4'd1, 1'b0);
        checkCycle("stall1", 4'd0, C_FETCH_WT, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0);
        checkCycle("stall2", 4'd0, C_FETCH_WT, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0);
        checkCycle("stall3", 4'd0, C_FETCH_WT, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b1);
        checkCycle("fetch_go", 4'd0, C_FETCH_GO, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0);
        checkCycle("decode", 4'd1, C_DECODE, 1'b0);

        $display("[TB] load");
        applyStimulus(1'b1, 4'd3, 1'b0);
        checkCycle("memaddr", 4'd2, C_MEMADDR, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0);
        checkCycle("memread1", 4'd3, C_MEMREAD, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b1);
        checkCycle("memread2", 4'd3, C_MEMREAD, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkCycle("memwb", 4'd4, C_MEMWB, 1'b0);

        $display("[TB] branch");
        applyStimulus(1'b1, 4'd1, 1'b1);
        checkCycle("ld_done", 4'd0, C_FETCH_GO, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("retired_load", retired_cnt, 32'd1);
        checkOutput("cycles_load", cycle_cnt, 32'd9);
`endif
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkCycle("br_decode", 4'd1, C_DECODE, 1'b0);
        applyStimulus(1'b1, 4'd14, 1'b0);
        checkCycle("brcmp", 4'd8, C_BRCMP, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkCycle("brtake", 4'd14, C_BRTAKE, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b1);
        checkCycle("br_done", 4'd0, C_FETCH_GO, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("retired_branch", retired_cnt, 32'd2);
`endif

        $display("[TB] illegal opcode");
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkCycle("illegal", 4'd1, C_DECODE, 1'b1);
        applyStimulus(1'b1, 4'd1, 1'b1);
        checkCycle("after_illegal", 4'd0, C_FETCH_GO, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("retired_illegal", retired_cnt, 32'd2);
`endif

        $display("[TB] reset during store stall");
        applyStimulus(1'b1, 4'd2, 1'b0);
        checkCycle("st_decode", 4'd1, C_DECODE, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0);
        checkCycle("st_memaddr", 4'd2, C_MEMADDR, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkCycle("memwrite", 4'd5, C_MEMWRITE, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkCycle("st_reset", 4'd5, C_ZERO, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0);
        checkCycle("post_reset", 4'd0, C_FETCH_WT, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("retired_cleared", retired_cnt, 32'd0);
        checkOutput("cycles_cleared", cycle_cnt, 32'd0);
`endif
        applyStimulus(1'b1, 4'd1, 1'b1);
        checkCycle("post_reset_go", 4'd0, C_FETCH_GO, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("cycles_one", cycle_cnt, 32'd1);
`endif

        $display("[TB] remaining states");
        applyStimulus(1'b1, stateSeq[0], 1'b0);
        checkCycle("sweep_decode", 4'd1, C_DECODE, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i < 7) ? stateSeq[i + 1] : 4'd0, 1'b0);
            checkCycle($sformatf("sweep_s%0d", stateSeq[i]), stateSeq[i], ctrlSeq[i], 1'b0);
        end
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkCycle("sweep_end", 4'd0, C_FETCH_WT, 1'b0);
`ifdef CU_PERF_CNT_EN
        checkOutput("retired_sweep", retired_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
